// File: rtl/sc_pkg.sv
// Shared definitions for the single-cycle fetch unit: next-PC select codes,
// fetch FSM state encoding and the branch-offset helper.
package sc_pkg;

   // Next-PC select codes as produced by sc_cu (z already folded into bit 0)
   localparam logic [1:0] PCS_SEQ = 2'b00;
   localparam logic [1:0] PCS_BR  = 2'b01;
   localparam logic [1:0] PCS_JR  = 2'b10;
   localparam logic [1:0] PCS_J   = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_REQ  = 2'b01,
      ST_EXEC = 2'b10,
      ST_HALT = 2'b11
   } state_t;

   // Sign-extended 16-bit immediate scaled to a byte offset (word index << 2)
   function automatic logic [31:0] branch_offset(input logic [15:0] imm);
      return {{14{imm[15]}}, imm, 2'b00};
   endfunction

endpackage

// File: rtl/sc_npc.sv
// Combinational next-PC selection. All targets are formed from pc+4 so the
// j/jal region bits come from the delay-slot-free sequential address.
module sc_npc
   import sc_pkg::*;
(
   input  logic [31:0] pc4,
   input  logic [25:0] inst_idx,
   input  logic [31:0] ra,
   input  logic [1:0]  pcsource,
   output logic [31:0] npc,
   output logic        misalign
);

   // Select the next PC; a jr target with nonzero low bits is flagged and word-aligned
   always_comb begin
      npc      = pc4;
      misalign = 1'b0;
      case (pcsource)
         PCS_SEQ: npc = pc4;
         PCS_BR:  npc = pc4 + branch_offset(inst_idx[15:0]);
         PCS_JR: begin
            npc      = {ra[31:2], 2'b00};
            misalign = (ra[1:0] != 2'b00);
         end
         PCS_J:   npc = {pc4[31:28], inst_idx, 2'b00};
         default: npc = pc4;
      endcase
   end

endmodule

// File: rtl/sc_fetch.sv
// Instruction-fetch unit: owns the PC, fetches one word per instruction over
// a req/ack port, presents it for one (or more, while stalled) execute cycles,
// then advances to the PC chosen by the control unit. A missing ack halts the
// unit with a sticky fault; a misaligned jr target only raises the fault.
module sc_fetch
   import sc_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          TIMEOUT  = 16
)(
   input  logic        clock,
   input  logic        resetn,
   input  logic [1:0]  pcsource,
   input  logic [31:0] ra,
   input  logic        stall,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] inst,
   output logic        inst_valid,
   output logic [31:0] pc,
   output logic [31:0] pc4,
   output logic        fault
);

   localparam int             CW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

   state_t        state;
   logic [CW-1:0] cnt;
   logic [31:0]   npc;
   logic          misalign;

   sc_npc u_npc (
      .pc4      (pc4),
      .inst_idx (inst[25:0]),
      .ra       (ra),
      .pcsource (pcsource),
      .npc      (npc),
      .misalign (misalign)
   );

   // The request address is always the current PC
   assign imem_addr  = pc;

   // The instruction is live exactly while the FSM sits in EXEC
   assign inst_valid = (state == ST_EXEC);

   // Fetch FSM with PC/instruction registers, timeout counter and sticky fault
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state    <= ST_IDLE;
         pc       <= RESET_PC;
         pc4      <= RESET_PC + 32'd4;
         inst     <= '0;
         imem_req <= 1'b0;
         fault    <= 1'b0;
         cnt      <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               imem_req <= 1'b1;
               state    <= ST_REQ;
            end
            ST_REQ: begin
               // An ack always wins, even on the last allowed cycle
               if (imem_ack) begin
                  inst     <= imem_rdata;
                  cnt      <= '0;
                  imem_req <= 1'b0;
                  state    <= ST_EXEC;
               end else if (cnt == CNT_LAST) begin
                  fault    <= 1'b1;
                  imem_req <= 1'b0;
                  state    <= ST_HALT;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_EXEC: begin
               if (!stall) begin
                  pc       <= npc;
                  pc4      <= npc + 32'd4;
                  imem_req <= 1'b1;
                  state    <= ST_REQ;
                  if (misalign) fault <= 1'b1;
               end
            end
            ST_HALT: state <= ST_HALT;
            default: state <= ST_HALT;
         endcase
      end
   end

endmodule

// File: tb/tb_sc_fetch.sv
// Scoreboard bench for sc_fetch: a driver plays the instruction memory and
// the control unit, pushing expected fetch addresses and executed
// instructions into queues; a negedge monitor pops and compares them.
module tb_sc_fetch;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int          TIMEOUT  = 16;

   logic        clock = 1'b0;
   logic        resetn = 1'b0;
   logic [1:0]  pcsource = 2'b00;
   logic [31:0] ra = '0;
   logic        stall = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic [31:0] inst;
   logic        inst_valid;
   logic [31:0] pc;
   logic [31:0] pc4;
   logic        fault;

   sc_fetch #(.RESET_PC(RESET_PC), .TIMEOUT(TIMEOUT)) dut (
      .clock      (clock),
      .resetn     (resetn),
      .pcsource   (pcsource),
      .ra         (ra),
      .stall      (stall),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .inst       (inst),
      .inst_valid (inst_valid),
      .pc         (pc),
      .pc4        (pc4),
      .fault      (fault)
   );

   always #5 clock = ~clock;

   typedef struct { logic [31:0] addr; logic flt; } req_exp_t;
   typedef struct { logic [31:0] pc; logic [31:0] word; int len; } exec_exp_t;

   req_exp_t  req_q[$];
   exec_exp_t exec_q[$];

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   logic [31:0] m_pc;
   logic        m_fault;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Architectural next-PC rules, written as plain arithmetic
   task automatic model_step(input logic [1:0] psel, input logic [31:0] rav, input logic [31:0] word);
      logic [31:0] seq;
      int          off;
      seq = m_pc + 32'd4;
      case (psel)
         2'd0: m_pc = seq;
         2'd1: begin
            off  = $signed(word[15:0]);
            m_pc = seq + 32'(off * 4);
         end
         2'd2: begin
            m_pc = rav - (rav % 32'd4);
            if ((rav % 32'd4) != 0) m_fault = 1'b1;
         end
         default: m_pc = (seq & 32'hF000_0000) | ((word & 32'h03FF_FFFF) << 2);
      endcase
   endtask

   task automatic wait_req();
      int k = 0;
      while (imem_req !== 1'b1 && k < 20) begin
         @(posedge clock); #1;
         k++;
      end
      check("wait_req", {31'd0, imem_req}, 32'd1);
   endtask

   // One full instruction: w wait cycles in REQ, s stall cycles in EXEC
   task automatic fetch_one(input int w, input int s, input logic [31:0] word,
                            input logic [1:0] psel, input logic [31:0] rav);
      exec_exp_t e;
      req_exp_t  r;
      wait_req();
      repeat (w) begin
         imem_ack = 1'b0;
         @(posedge clock); #1;
      end
      imem_ack   = 1'b1;
      imem_rdata = word;
      e.pc = m_pc; e.word = word; e.len = s + 1;
      exec_q.push_back(e);
      @(posedge clock); #1;
      repeat (s) begin
         stall      = 1'b1;
         pcsource   = 2'($urandom);
         ra         = $urandom;
         imem_ack   = 1'($urandom);
         imem_rdata = $urandom;
         @(posedge clock); #1;
      end
      stall    = 1'b0;
      pcsource = psel;
      ra       = rav;
      imem_ack = 1'($urandom);
      model_step(psel, rav, word);
      r.addr = m_pc; r.flt = m_fault;
      req_q.push_back(r);
      @(posedge clock); #1;
      imem_ack = 1'b0;
   endtask

   // Monitor: compares each new request and each executed instruction
   logic      prev_req = 1'b0;
   logic      prev_valid = 1'b0;
   int        cur_len = 0;
   exec_exp_t cur_e;

   always @(negedge clock) begin
      req_exp_t r;
      if (imem_req === 1'b1 && prev_req !== 1'b1) begin
         if (req_q.size() == 0) begin
            check("unexpected_req", imem_addr, 32'hFFFF_FFFF);
         end else begin
            r = req_q.pop_front();
            check("req_addr", imem_addr, r.addr);
            check("req_pc", pc, r.addr);
            check("req_fault", {31'd0, fault}, {31'd0, r.flt});
         end
      end
      if (inst_valid === 1'b1) begin
         if (prev_valid !== 1'b1) begin
            if (exec_q.size() == 0) begin
               check("unexpected_exec", inst, 32'hFFFF_FFFF);
               cur_e.pc = pc; cur_e.word = inst; cur_e.len = 1;
            end else begin
               cur_e = exec_q.pop_front();
               check("exec_inst", inst, cur_e.word);
               check("exec_pc", pc, cur_e.pc);
               check("exec_pc4", pc4, cur_e.pc + 32'd4);
               $display("exec pc=%h inst=%h pc4=%h fault=%0b", pc, inst, pc4, fault);
            end
            cur_len = 1;
         end else begin
            cur_len++;
            check("stall_pc_hold", pc, cur_e.pc);
            check("stall_inst_hold", inst, cur_e.word);
         end
      end else if (prev_valid === 1'b1) begin
         check("valid_len", 32'(cur_len), 32'(cur_e.len));
      end
      prev_req   = imem_req;
      prev_valid = inst_valid;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      req_exp_t r;
      logic [31:0] rav;
      m_pc    = RESET_PC;
      m_fault = 1'b0;
      r.addr = RESET_PC; r.flt = 1'b0;
      req_q.push_back(r);
      #3;
      check("reset_req", {31'd0, imem_req}, 32'd0);
      check("reset_pc", pc, RESET_PC);
      check("reset_inst", inst, 32'd0);
      check("reset_valid", {31'd0, inst_valid}, 32'd0);
      check("reset_fault", {31'd0, fault}, 32'd0);
      #20 resetn = 1'b1;

      // directed sequence
      fetch_one(0, 0, 32'h2000_0001, 2'b00, 32'h0);           // 0 -> 4
      fetch_one(1, 0, 32'h0800_0004, 2'b11, 32'h0);           // j -> 0x10
      fetch_one(0, 0, 32'h1000_FFFF, 2'b01, 32'h0);           // branch -4 -> 0x10
      fetch_one(2, 0, 32'h0000_0008, 2'b10, 32'h1000_0040);   // jr -> 0x1000_0040
      fetch_one(0, 0, 32'h0C00_0100, 2'b11, 32'h0);           // jal -> 0x1000_0400
      fetch_one(0, 0, 32'h0000_0008, 2'b10, 32'h0000_0203);   // misaligned jr -> 0x200
      fetch_one(0, 3, 32'h0000_0000, 2'b00, 32'h0);           // stall 3 cycles
      fetch_one(0, 0, 32'h0000_0008, 2'b10, 32'hFFFF_FFFC);   // jr to top of memory
      fetch_one(1, 0, 32'h0000_0000, 2'b00, 32'h0);           // wrap to 0
      fetch_one(0, 0, 32'h2000_0001, 2'b00, 32'h0);

      // randomized instructions
      for (int i = 0; i < 150; i++) begin
         rav = $urandom;
         if ($urandom_range(3, 0) != 0) rav[1:0] = 2'b00;
         fetch_one($urandom_range(4, 0), $urandom_range(3, 0) == 0 ? $urandom_range(3, 1) : 0,
                   $urandom, 2'($urandom), rav);
      end

      // asynchronous reset in the middle of a REQ
      wait_req();
      @(negedge clock); #1;
      resetn   = 1'b0;
      imem_ack = 1'b1;
      #1;
      check("midreq_reset_req", {31'd0, imem_req}, 32'd0);
      check("midreq_reset_pc", pc, RESET_PC);
      check("midreq_reset_fault", {31'd0, fault}, 32'd0);
      m_pc    = RESET_PC;
      m_fault = 1'b0;
      r.addr = RESET_PC; r.flt = 1'b0;
      req_q.push_back(r);
      repeat (2) @(posedge clock);
      #3 resetn = 1'b1;
      @(posedge clock); #1;                 // IDLE -> REQ, stale ack ignored
      imem_ack = 1'b0;
      check("post_reset_valid", {31'd0, inst_valid}, 32'd0);
      check("post_reset_req", {31'd0, imem_req}, 32'd1);

      // imem timeout: ack withheld for TIMEOUT REQ cycles
      repeat (TIMEOUT - 1) @(posedge clock);
      #1;
      check("timeout_last_req", {31'd0, imem_req}, 32'd1);
      check("timeout_last_fault", {31'd0, fault}, 32'd0);
      @(posedge clock); #1;
      check("timeout_req", {31'd0, imem_req}, 32'd0);
      check("timeout_fault", {31'd0, fault}, 32'd1);
      for (int i = 0; i < 30; i++) begin
         imem_ack = 1'($urandom);
         @(posedge clock); #1;
         check("halt_req", {31'd0, imem_req}, 32'd0);
         check("halt_valid", {31'd0, inst_valid}, 32'd0);
         check("halt_fault", {31'd0, fault}, 32'd1);
      end
      $display("timeout test: halted, fault=%0b", fault);

      @(negedge clock); #1;
      check("req_q_empty", 32'(req_q.size()), 32'd0);
      check("exec_q_empty", 32'(exec_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
